// File: rtl/alu_entry_sequencer.sv
// Operand-entry front end: synchronizes and debounces the enter button, then steps
// through A / B / Op capture with one-cycle load strobes and a result-update strobe.
module alu_entry_sequencer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_switches,
  input  logic             i_enter,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_data,
  output logic             o_load_A,
  output logic             o_load_B,
  output logic             o_load_Op,
  output logic             o_update_Res,
  output logic [3:0]       o_state_leds
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    UPDATE,
    SHOW
  } state_t;

  logic          enter_s1, enter_s2;
  logic          clear_s1, clear_s2;
  logic          deb, deb_q;
  logic [CW-1:0] cnt;
  logic          press;

  state_t           state, state_n;
  logic [WIDTH-1:0] data_n;
  logic             load_a_n, load_b_n, load_op_n, update_n;
  logic [3:0]       leds_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      enter_s1 <= 1'b0;
      enter_s2 <= 1'b0;
      clear_s1 <= 1'b0;
      clear_s2 <= 1'b0;
      deb      <= 1'b0;
      deb_q    <= 1'b0;
      cnt      <= '0;
    end else begin
      enter_s1 <= i_enter;
      enter_s2 <= enter_s1;
      clear_s1 <= i_clear;
      clear_s2 <= clear_s1;
      deb_q    <= deb;
      // Level is accepted on the cycle the mismatch run would reach DEBOUNCE_CYCLES.
      if (enter_s2 != deb) begin
        if (cnt == CNT_LAST) begin
          deb <= enter_s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = deb & ~deb_q;

  always_comb begin
    state_n   = state;
    data_n    = o_data;
    load_a_n  = 1'b0;
    load_b_n  = 1'b0;
    load_op_n = 1'b0;
    update_n  = 1'b0;
    case (state)
      WAIT_A: if (press) begin
        data_n   = i_switches;
        load_a_n = 1'b1;
        state_n  = WAIT_B;
      end
      WAIT_B: if (press) begin
        data_n   = i_switches;
        load_b_n = 1'b1;
        state_n  = WAIT_OP;
      end
      WAIT_OP: if (press) begin
        data_n    = i_switches;
        load_op_n = 1'b1;
        state_n   = UPDATE;
      end
      UPDATE: begin
        update_n = 1'b1;
        state_n  = SHOW;
      end
      SHOW: if (press) state_n = WAIT_A;
      default: state_n = WAIT_A;
    endcase
    // Clear overrides everything, including a press in the same cycle.
    if (clear_s2) begin
      state_n   = WAIT_A;
      data_n    = '0;
      load_a_n  = 1'b0;
      load_b_n  = 1'b0;
      load_op_n = 1'b0;
      update_n  = 1'b0;
    end
    case (state_n)
      WAIT_A:  leds_n = 4'b0001;
      WAIT_B:  leds_n = 4'b0010;
      WAIT_OP: leds_n = 4'b0100;
      default: leds_n = 4'b1000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= WAIT_A;
      o_data       <= '0;
      o_load_A     <= 1'b0;
      o_load_B     <= 1'b0;
      o_load_Op    <= 1'b0;
      o_update_Res <= 1'b0;
      o_state_leds <= 4'b0001;
    end else begin
      state        <= state_n;
      o_data       <= data_n;
      o_load_A     <= load_a_n;
      o_load_B     <= load_b_n;
      o_load_Op    <= load_op_n;
      o_update_Res <= update_n;
      o_state_leds <= leds_n;
    end
  end

endmodule

// File: tb/tb_alu_entry_sequencer.sv
// Directed bench for alu_entry_sequencer with DEBOUNCE_CYCLES=4.
module tb_alu_entry_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] i_switches;
  logic       i_enter;
  logic       i_clear;
  logic [7:0] o_data;
  logic       o_load_A, o_load_B, o_load_Op, o_update_Res;
  logic [3:0] o_state_leds;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int multi  = 0;
  int c0;
  int log_code[$];
  int log_cyc[$];
  int log_dat[$];

  alu_entry_sequencer #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_switches   (i_switches),
    .i_enter      (i_enter),
    .i_clear      (i_clear),
    .o_data       (o_data),
    .o_load_A     (o_load_A),
    .o_load_B     (o_load_B),
    .o_load_Op    (o_load_Op),
    .o_update_Res (o_update_Res),
    .o_state_leds (o_state_leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then record any strobe seen after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (o_load_A)     begin log_code.push_back(1); log_cyc.push_back(cyc); log_dat.push_back(int'(o_data)); end
    if (o_load_B)     begin log_code.push_back(2); log_cyc.push_back(cyc); log_dat.push_back(int'(o_data)); end
    if (o_load_Op)    begin log_code.push_back(3); log_cyc.push_back(cyc); log_dat.push_back(int'(o_data)); end
    if (o_update_Res) begin log_code.push_back(4); log_cyc.push_back(cyc); log_dat.push_back(int'(o_data)); end
    if (32'(o_load_A) + 32'(o_load_B) + 32'(o_load_Op) + 32'(o_update_Res) > 1) multi++;
  endtask

  task automatic clear_log();
    log_code.delete();
    log_cyc.delete();
    log_dat.delete();
  endtask

  task automatic press(input logic [7:0] sw, input int hold, input int rel);
    i_switches = sw;
    i_enter    = 1'b1;
    repeat (hold) tick();
    i_enter = 1'b0;
    repeat (rel) tick();
  endtask

  initial begin
    reset      = 1'b0;
    i_switches = 8'h00;
    i_enter    = 1'b0;
    i_clear    = 1'b0;

    // Reset state
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("reset_data", 32'(o_data), 32'h00);
    check("reset_strobes", 32'({o_load_A, o_load_B, o_load_Op, o_update_Res}), 32'h0);
    check("reset_leds", 32'(o_state_leds), 32'h1);

    // Clean press held 20 cycles: strobe after the 7th edge (E6) counted from the first sample
    clear_log();
    c0 = cyc;
    press(8'h3C, 20, 0);
    check("single_cnt", 32'(log_code.size()), 32'd1);
    if (log_code.size() >= 1) begin
      check("single_code", 32'(log_code[0]), 32'd1);
      check("single_time", 32'(log_cyc[0]), 32'(c0 + 7));
      check("single_data", 32'(log_dat[0]), 32'h3C);
    end
    check("single_leds", 32'(o_state_leds), 32'h2);
    check("single_data_hold", 32'(o_data), 32'h3C);
    repeat (10) tick();

    // Clear to return to WAIT_A, then full sequence
    i_clear = 1'b1;
    repeat (3) tick();
    i_clear = 1'b0;
    repeat (3) tick();
    check("clear_leds", 32'(o_state_leds), 32'h1);
    check("clear_data", 32'(o_data), 32'h00);

    clear_log();
    press(8'h12, 10, 10);
    press(8'h05, 10, 10);
    press(8'h02, 10, 10);
    check("seq_cnt", 32'(log_code.size()), 32'd4);
    if (log_code.size() == 4) begin
      check("seq_code0", 32'(log_code[0]), 32'd1);
      check("seq_code1", 32'(log_code[1]), 32'd2);
      check("seq_code2", 32'(log_code[2]), 32'd3);
      check("seq_code3", 32'(log_code[3]), 32'd4);
      check("seq_dat_a", 32'(log_dat[0]), 32'h12);
      check("seq_dat_b", 32'(log_dat[1]), 32'h05);
      check("seq_dat_op", 32'(log_dat[2]), 32'h02);
      check("seq_res_next", 32'(log_cyc[3]), 32'(log_cyc[2] + 1));
    end
    check("seq_leds_show", 32'(o_state_leds), 32'h8);
    clear_log();
    press(8'hFF, 10, 10);
    check("fourth_cnt", 32'(log_code.size()), 32'd0);
    check("fourth_leds", 32'(o_state_leds), 32'h1);
    check("fourth_data", 32'(o_data), 32'h02);

    // Bouncing enter: 2-cycle glitches, then a stable high
    clear_log();
    i_switches = 8'h5A;
    i_enter = 1'b1; repeat (2) tick();
    i_enter = 1'b0; repeat (2) tick();
    i_enter = 1'b1; repeat (2) tick();
    i_enter = 1'b0; repeat (2) tick();
    c0 = cyc;
    press(8'h5A, 15, 10);
    check("bounce_cnt", 32'(log_code.size()), 32'd1);
    if (log_code.size() >= 1) begin
      check("bounce_code", 32'(log_code[0]), 32'd1);
      check("bounce_time", 32'(log_cyc[0]), 32'(c0 + 7));
      check("bounce_data", 32'(log_dat[0]), 32'h5A);
    end

    // In WAIT_B: synchronized clear lands exactly on the press edge
    clear_log();
    i_switches = 8'hA7;
    i_enter    = 1'b1;
    repeat (4) tick();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    tick();
    tick();
    check("clrpress_loadb", 32'(o_load_B), 32'd0);
    check("clrpress_data", 32'(o_data), 32'h00);
    check("clrpress_leds", 32'(o_state_leds), 32'h1);
    repeat (8) tick();
    i_enter = 1'b0;
    repeat (10) tick();
    check("clrpress_cnt", 32'(log_code.size()), 32'd0);
    check("clrpress_leds_after", 32'(o_state_leds), 32'h1);

    // Reset in the load_Op cycle abandons the update strobe
    press(8'h11, 10, 10);
    press(8'h22, 10, 10);
    clear_log();
    i_switches = 8'h03;
    i_enter    = 1'b1;
    repeat (7) tick();
    check("rst_op_strobe", 32'(o_load_Op), 32'd1);
    reset   = 1'b0;
    i_enter = 1'b0;
    tick();
    check("rst_res", 32'(o_update_Res), 32'd0);
    check("rst_strobes", 32'({o_load_A, o_load_B, o_load_Op, o_update_Res}), 32'h0);
    check("rst_leds", 32'(o_state_leds), 32'h1);
    check("rst_data", 32'(o_data), 32'h00);
    reset = 1'b1;
    repeat (12) tick();
    check("rst_log_cnt", 32'(log_code.size()), 32'd1);

    check("one_strobe_max", 32'(multi), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
